// File: rtl/sdram_pkg.sv
// Shared types and default sizes for the SDRAM FIFO controller.
package sdram_pkg;

  localparam int unsigned DEPTH_DEFAULT = 1024;
  localparam int unsigned DW_DEFAULT    = 16;
  localparam int unsigned AW_DEFAULT    = 24;

  // Arbiter states: idle, write burst to SDRAM, read burst from SDRAM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with fill count.
// When empty, head keeps showing the last word popped (zero after reset).
module sync_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [DW-1:0] last_q, last_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (cnt_q == CNT_MAX);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = empty ? last_q : mem_q[rd_ptr_q];

  // Next pointers, count and held head word; a full FIFO drops pushes, an empty one drops pops.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      last_d   = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array, left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer, count and held-head registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/sdram_fifo_ctrl.sv
// Buffers user data in a write FIFO and a read FIFO and arbitrates burst
// transfers between them and an SDRAM controller; write bursts have priority.
module sdram_fifo_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_end,
  input  logic                   wr_fifo_wr_en,
  input  logic [DW-1:0]          wr_fifo_wr_data,
  input  logic [AW-1:0]          wr_b_addr,
  input  logic [AW-1:0]          wr_e_addr,
  input  logic [9:0]             wr_burst_len,
  input  logic                   rd_fifo_rd_en,
  output logic [DW-1:0]          rd_fifo_rd_data,
  input  logic [AW-1:0]          rd_b_addr,
  input  logic [AW-1:0]          rd_e_addr,
  input  logic [9:0]             rd_burst_len,
  input  logic                   read_valid,
  output logic                   wr_fifo_full,
  output logic                   rd_fifo_empty,
  output logic [$clog2(DEPTH):0] wr_fifo_cnt,
  output logic [$clog2(DEPTH):0] rd_fifo_cnt,
  output logic                   sdram_wr_req,
  output logic [AW-1:0]          sdram_wr_addr,
  output logic [DW-1:0]          sdram_wr_data,
  input  logic                   sdram_wr_ack,
  output logic                   sdram_rd_req,
  output logic [AW-1:0]          sdram_rd_addr,
  input  logic                   sdram_rd_ack,
  input  logic [DW-1:0]          sdram_rd_data
);

  arb_state_e    state_q, state_d;
  logic          wr_req_q, wr_req_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_ack_q, wr_ack_d;
  logic          rd_ack_q, rd_ack_d;
  logic          wr_go, rd_go;
  logic          wr_pop, rd_push;
  logic          wr_fifo_empty_i, rd_fifo_full_i;

  // Advance a burst address by len, wrapping to the window start at or past the end.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                              input logic [9:0]    len,
                                              input logic [AW-1:0] b_addr,
                                              input logic [AW-1:0] e_addr);
    logic [AW:0] sum;
    sum = {1'b0, addr} + (AW + 1)'(len);
    if (sum >= {1'b0, e_addr}) begin
      next_addr = b_addr;
    end else begin
      next_addr = sum[AW-1:0];
    end
  endfunction

  assign wr_pop  = (state_q == ST_WR) & sdram_wr_ack & ~wr_fifo_empty_i;
  assign rd_push = (state_q == ST_RD) & sdram_rd_ack & ~rd_fifo_full_i;

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_fifo_wr_en),
    .push_data (wr_fifo_wr_data),
    .pop       (wr_pop),
    .head      (sdram_wr_data),
    .count     (wr_fifo_cnt),
    .full      (wr_fifo_full),
    .empty     (wr_fifo_empty_i)
  );

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_push),
    .push_data (sdram_rd_data),
    .pop       (rd_fifo_rd_en),
    .head      (rd_fifo_rd_data),
    .count     (rd_fifo_cnt),
    .full      (rd_fifo_full_i),
    .empty     (rd_fifo_empty)
  );

  // Arbiter next state: bursts start only from idle and end on the falling edge of their ack.
  always_comb begin
    wr_go = init_end && (wr_burst_len != 10'd0) &&
            (32'(wr_fifo_cnt) >= 32'(wr_burst_len));
    rd_go = init_end && read_valid && (rd_burst_len != 10'd0) &&
            (32'(rd_fifo_cnt) + 32'(rd_burst_len) <= 32'(DEPTH));
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_go) begin
          state_d = ST_WR;
        end else if (rd_go) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (wr_ack_q && !sdram_wr_ack) begin
          state_d   = ST_IDLE;
          wr_addr_d = next_addr(wr_addr_q, wr_burst_len, wr_b_addr, wr_e_addr);
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD: begin
        if (rd_ack_q && !sdram_rd_ack) begin
          state_d   = ST_IDLE;
          rd_addr_d = next_addr(rd_addr_q, rd_burst_len, rd_b_addr, rd_e_addr);
        end else begin
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    wr_req_d = (state_d == ST_WR);
    rd_req_d = (state_d == ST_RD);
    wr_ack_d = (state_q == ST_WR) & sdram_wr_ack;
    rd_ack_d = (state_q == ST_RD) & sdram_rd_ack;
  end

  // Arbiter registers: state, registered requests, burst addresses and ack history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_addr_q <= wr_b_addr;
      rd_addr_q <= rd_b_addr;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
    end
  end

  assign sdram_wr_req  = wr_req_q;
  assign sdram_rd_req  = rd_req_q;
  assign sdram_wr_addr = wr_addr_q;
  assign sdram_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Self-checking bench: queue-based reference model plus an SDRAM responder.
`timescale 1ns/1ps
module tb_sdram_fifo_ctrl;

  localparam int DEPTH = 1024;
  localparam int DW    = 16;
  localparam int AW    = 24;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_end;
  logic          wr_fifo_wr_en;
  logic [DW-1:0] wr_fifo_wr_data;
  logic [AW-1:0] wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr;
  logic [9:0]    wr_burst_len, rd_burst_len;
  logic          rd_fifo_rd_en;
  logic [DW-1:0] rd_fifo_rd_data;
  logic          read_valid;
  logic          wr_fifo_full, rd_fifo_empty;
  logic [CW-1:0] wr_fifo_cnt, rd_fifo_cnt;
  logic          sdram_wr_req, sdram_rd_req;
  logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;
  logic [DW-1:0] sdram_wr_data, sdram_rd_data;
  logic          sdram_wr_ack, sdram_rd_ack;

  always #5 clk = ~clk;

  sdram_fifo_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .init_end(init_end),
    .wr_fifo_wr_en(wr_fifo_wr_en), .wr_fifo_wr_data(wr_fifo_wr_data),
    .wr_b_addr(wr_b_addr), .wr_e_addr(wr_e_addr), .wr_burst_len(wr_burst_len),
    .rd_fifo_rd_en(rd_fifo_rd_en), .rd_fifo_rd_data(rd_fifo_rd_data),
    .rd_b_addr(rd_b_addr), .rd_e_addr(rd_e_addr), .rd_burst_len(rd_burst_len),
    .read_valid(read_valid), .wr_fifo_full(wr_fifo_full), .rd_fifo_empty(rd_fifo_empty),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr), .sdram_wr_data(sdram_wr_data),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr),
    .sdram_rd_ack(sdram_rd_ack), .sdram_rd_data(sdram_rd_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents as queues, burst kind 0=none 1=write 2=read.
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] m_head;
  int  burst;
  int  m_wa, m_ra;
  bit  m_wprev, m_rprev;

  // Responder state and observation logs.
  int  w_lat, w_sent, r_lat, r_sent;
  bit  spur;
  logic [DW-1:0] acked[$];
  logic [DW-1:0] rd_fed[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // SDRAM side: contiguous ack bursts after a random latency, optional stray acks.
  task automatic drive_sdram();
    if (burst == 1) begin
      if (w_lat > 0) begin sdram_wr_ack = 1'b0; w_lat--; end
      else if (w_sent < int'(wr_burst_len)) begin
        sdram_wr_ack = 1'b1; w_sent++; acked.push_back(sdram_wr_data);
      end else sdram_wr_ack = 1'b0;
    end else begin
      w_lat = $urandom_range(3); w_sent = 0;
      sdram_wr_ack = spur && ($urandom_range(7) == 0);
    end
    sdram_rd_data = DW'($urandom);
    if (burst == 2) begin
      if (r_lat > 0) begin sdram_rd_ack = 1'b0; r_lat--; end
      else if (r_sent < int'(rd_burst_len)) begin
        sdram_rd_ack = 1'b1; r_sent++; rd_fed.push_back(sdram_rd_data);
      end else sdram_rd_ack = 1'b0;
    end else begin
      r_lat = $urandom_range(3); r_sent = 0;
      sdram_rd_ack = spur && ($urandom_range(7) == 0);
    end
  endtask

  // Apply the effect of the coming clock edge to the model.
  task automatic model_step();
    int ws, rs, nb;
    if (rst) begin
      wq.delete(); rq.delete(); burst = 0; m_head = '0;
      m_wa = int'(wr_b_addr); m_ra = int'(rd_b_addr); m_wprev = 0; m_rprev = 0;
      return;
    end
    ws = wq.size(); rs = rq.size();
    if (burst == 1 && sdram_wr_ack && ws > 0) void'(wq.pop_front());
    if (wr_fifo_wr_en && ws < DEPTH) wq.push_back(wr_fifo_wr_data);
    if (rd_fifo_rd_en && rs > 0) m_head = rq.pop_front();
    if (burst == 2 && sdram_rd_ack && rs < DEPTH) rq.push_back(sdram_rd_data);
    nb = burst;
    if (burst == 0) begin
      if (init_end && wr_burst_len != 0 && ws >= int'(wr_burst_len)) nb = 1;
      else if (init_end && read_valid && rd_burst_len != 0 && rs + int'(rd_burst_len) <= DEPTH) nb = 2;
    end else if (burst == 1 && m_wprev && !sdram_wr_ack) begin
      nb = 0;
      m_wa = (m_wa + int'(wr_burst_len) >= int'(wr_e_addr)) ? int'(wr_b_addr) : m_wa + int'(wr_burst_len);
    end else if (burst == 2 && m_rprev && !sdram_rd_ack) begin
      nb = 0;
      m_ra = (m_ra + int'(rd_burst_len) >= int'(rd_e_addr)) ? int'(rd_b_addr) : m_ra + int'(rd_burst_len);
    end
    m_wprev = (burst == 1) && sdram_wr_ack;
    m_rprev = (burst == 2) && sdram_rd_ack;
    burst = nb;
  endtask

  task automatic check_outputs();
    check_val("wr_req", 32'(sdram_wr_req), 32'(burst == 1));
    check_val("rd_req", 32'(sdram_rd_req), 32'(burst == 2));
    check_val("wr_addr", 32'(sdram_wr_addr), m_wa);
    check_val("rd_addr", 32'(sdram_rd_addr), m_ra);
    check_val("wr_cnt", 32'(wr_fifo_cnt), wq.size());
    check_val("rd_cnt", 32'(rd_fifo_cnt), rq.size());
    check_val("wr_full", 32'(wr_fifo_full), 32'(wq.size() == DEPTH));
    check_val("rd_empty", 32'(rd_fifo_empty), 32'(rq.size() == 0));
    check_val("rd_data", 32'(rd_fifo_rd_data), 32'((rq.size() > 0) ? rq[0] : m_head));
    if (wq.size() > 0) check_val("wr_data", 32'(sdram_wr_data), 32'(wq[0]));
  endtask

  task automatic cycle();
    drive_sdram();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_user();
    wr_fifo_wr_en = 1'b0; rd_fifo_rd_en = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1; init_end = 1'b0; read_valid = 1'b0; spur = 1'b0;
    idle_user(); wr_fifo_wr_data = '0;
    wr_b_addr = 24'd0; wr_e_addr = 24'd16; wr_burst_len = 10'd8;
    rd_b_addr = 24'd100; rd_e_addr = 24'd200; rd_burst_len = 10'd4;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_rd_data = '0;
    burst = 0; m_head = '0;
    cycle(); cycle();
    check_val("rst_rd_empty", 32'(rd_fifo_empty), 32'd1);
    check_val("rst_rd_data", 32'(rd_fifo_rd_data), 32'd0);
    check_val("rst_rd_addr", 32'(sdram_rd_addr), 32'd100);
    rst = 1'b0; init_end = 1'b1;

    // Eight words, one write burst of eight; then a second burst wraps the address.
    for (int r = 0; r < 2; r++) begin
      acked.delete();
      for (int i = 0; i < 8; i++) begin
        wr_fifo_wr_en = 1'b1; wr_fifo_wr_data = DW'(r * 100 + i); cycle();
      end
      idle_user();
      for (int i = 0; i < 30; i++) cycle();
      check_val("burst_words", acked.size(), 32'd8);
      for (int i = 0; i < acked.size(); i++) check_val("burst_order", 32'(acked[i]), r * 100 + i);
      check_val("burst_addr", 32'(sdram_wr_addr), (r == 0) ? 32'd8 : 32'd0);
      check_val("burst_cnt", 32'(wr_fifo_cnt), 32'd0);
    end

    // Write and read eligible together: write goes first.
    init_end = 1'b0; read_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_fifo_wr_en = 1'b1; wr_fifo_wr_data = DW'(16'h0a00 + i); cycle();
    end
    idle_user(); rd_fed.delete();
    init_end = 1'b1; cycle();
    check_val("prio_wr", 32'(sdram_wr_req), 32'd1);
    check_val("prio_rd", 32'(sdram_rd_req), 32'd0);
    k = 0;
    while (!(burst == 0 && rq.size() >= 4) && k < 80) begin cycle(); k++; end
    check_val("rd_burst_timeout", 32'(k < 80), 32'd1);
    read_valid = 1'b0;
    cycle();
    check_val("rd_cnt_4", 32'(rd_fifo_cnt), 32'd4);
    check_val("rd_fed_4", rd_fed.size(), 32'd4);

    // User drains A1..A4, then pops from empty.
    for (int i = 0; i < 4; i++) begin
      if (i < rd_fed.size()) check_val("rd_pop_order", 32'(rd_fifo_rd_data), 32'(rd_fed[i]));
      rd_fifo_rd_en = 1'b1; cycle();
    end
    for (int i = 0; i < 2; i++) begin
      rd_fifo_rd_en = 1'b1; cycle();
      check_val("empty_pop_empty", 32'(rd_fifo_empty), 32'd1);
      if (rd_fed.size() == 4) check_val("empty_pop_hold", 32'(rd_fifo_rd_data), 32'(rd_fed[3]));
    end
    idle_user();

    // Overfill the write FIFO while SDRAM is not ready.
    init_end = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr_fifo_wr_en = 1'b1; wr_fifo_wr_data = DW'($urandom); cycle();
    end
    idle_user();
    check_val("full_flag", 32'(wr_fifo_full), 32'd1);
    check_val("full_cnt", 32'(wr_fifo_cnt), DEPTH);

    // Reset in the middle of a write burst.
    init_end = 1'b1; wr_b_addr = 24'd40; wr_e_addr = 24'd4000;
    k = 0;
    while (!(burst == 1 && w_sent >= 3) && k < 20) begin cycle(); k++; end
    check_val("mid_burst_reach", 32'(k < 20), 32'd1);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_val("rst_mid_wr_req", 32'(sdram_wr_req), 32'd0);
    check_val("rst_mid_wr_cnt", 32'(wr_fifo_cnt), 32'd0);
    check_val("rst_mid_wr_addr", 32'(sdram_wr_addr), 32'd40);
    check_val("rst_mid_rd_addr", 32'(sdram_rd_addr), 32'd100);

    // Random traffic with stray acks, changing windows and burst lengths.
    spur = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      wr_fifo_wr_en = ($urandom_range(1) == 0);
      wr_fifo_wr_data = DW'($urandom);
      rd_fifo_rd_en = ($urandom_range(2) == 0);
      if ($urandom_range(49) == 0) read_valid = ~read_valid;
      init_end = ($urandom_range(19) != 0);
      if (burst == 0 && $urandom_range(31) == 0) begin
        wr_burst_len = 10'($urandom_range(16));
        rd_burst_len = 10'($urandom_range(16));
        wr_b_addr = 24'($urandom_range(100)); wr_e_addr = wr_b_addr + 24'($urandom_range(64, 1));
        rd_b_addr = 24'($urandom_range(100)); rd_e_addr = rd_b_addr + 24'($urandom_range(64, 1));
      end
      cycle();
    end
    idle_user();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
